apu_frame_sequencer: RTL and testbench

- Upstream timing stage for the APU channels. Takes the one-clk-per-CPU-cycle strobe and the $4017 register, and generates three strobes for the pulse, triangle and noise channels: apu_clk (every other CPU cycle), e_pulse (quarter frame) and l_pulse (half frame).
- Also owns the frame IRQ flag reported through $4015 and the CPU IRQ line.

---
 rtl/apu_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: apu_clk, quarter/half-frame strobes and frame IRQ.
// Define APU_FRAME_PAL_EN for PAL step values (NTSC values otherwise).
module apu_frame_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cyc,
  input  logic       wren_4017,
  input  logic [7:0] from_cpu,
  input  logic       rd_4015,
  output logic       apu_clk,
  output logic       e_pulse,
  output logic       l_pulse,
  output logic       frame_irq
);

`ifdef APU_FRAME_PAL_EN
  localparam int unsigned S_Q1 = 8313;
  localparam int unsigned S_Q2 = 16627;
  localparam int unsigned S_Q3 = 24939;
  localparam int unsigned S_Q4 = 33253;
  localparam int unsigned S_Q5 = 41565;
`else
  localparam int unsigned S_Q1 = 7457;
  localparam int unsigned S_Q2 = 14913;
  localparam int unsigned S_Q3 = 22371;
  localparam int unsigned S_Q4 = 29829;
  localparam int unsigned S_Q5 = 37281;
`endif

  localparam logic [CNT_W-1:0] C_Q1  = CNT_W'(S_Q1);
  localparam logic [CNT_W-1:0] C_Q2  = CNT_W'(S_Q2);
  localparam logic [CNT_W-1:0] C_Q3  = CNT_W'(S_Q3);
  localparam logic [CNT_W-1:0] C_Q4  = CNT_W'(S_Q4);
  localparam logic [CNT_W-1:0] C_Q5  = CNT_W'(S_Q5);
  localparam logic [CNT_W-1:0] C_IRQ = CNT_W'(S_Q4 - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dly_q, dly_d;
  logic             phase_q, phase_d;
  logic             mode_q, mode_d;
  logic             inhib_q, inhib_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             apu_clk_q, apu_clk_d;
  logic             e_q, e_d;
  logic             l_q, l_d;
  logic             irq_q, irq_d;

  logic ev_e;
  logic ev_l;
  logic ev_last;
  logic irq_hit;
  logic fire;
  logic irq_set;

  // Decode step events for the current count and mode.
  always_comb begin
    ev_e    = 1'b0;
    ev_l    = 1'b0;
    ev_last = 1'b0;
    unique case (1'b1)
      (cnt_q == C_Q1),
      (cnt_q == C_Q3): ev_e = 1'b1;
      (cnt_q == C_Q2): begin
        ev_e = 1'b1;
        ev_l = 1'b1;
      end
      (cnt_q == C_Q4): begin
        if (!mode_q) begin
          ev_e    = 1'b1;
          ev_l    = 1'b1;
          ev_last = 1'b1;
        end
      end
      (cnt_q == C_Q5): begin
        if (mode_q) begin
          ev_e    = 1'b1;
          ev_l    = 1'b1;
          ev_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // IRQ window and pending counter-reset expiry.
  always_comb begin
    irq_hit = !mode_q && !inhib_q &&
              ((cnt_q == C_IRQ) ||
               (cnt_q == C_Q4) ||
               ((cnt_q == '0) && wrap_q));
    fire    = pend_q && (dly_q == 3'd1) &&
              !wren_4017;
    irq_set = cpu_cyc && !fire && irq_hit;
  end

  // Next-state: phase, counter, pending reset, strobes.
  always_comb begin
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    inhib_d   = inhib_q;
    pend_d    = pend_q;
    wrap_d    = wrap_q;
    apu_clk_d = 1'b0;
    e_d       = 1'b0;
    l_d       = 1'b0;
    irq_d     = irq_q;

    if (cpu_cyc) begin
      phase_d   = ~phase_q;
      apu_clk_d = phase_q;
      if (fire) begin
        cnt_d  = '0;
        wrap_d = 1'b0;
        pend_d = 1'b0;
        e_d    = mode_q;
        l_d    = mode_q;
      end else begin
        e_d    = ev_e;
        l_d    = ev_l;
        wrap_d = ev_last;
        cnt_d  = ev_last ? '0 : cnt_q + C_ONE;
        if (pend_q) begin
          dly_d = dly_q - 3'd1;
        end
      end
    end

    // A write always (re)starts the reset delay.
    if (wren_4017) begin
      mode_d  = from_cpu[7];
      inhib_d = from_cpu[6];
      pend_d  = 1'b1;
      dly_d   = phase_q ? 3'd4 : 3'd3;
    end

    // Set beats a read-clear; inhibit write clears.
    if (wren_4017 && from_cpu[6]) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (rd_4015) begin
      irq_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dly_q     <= '0;
      phase_q   <= 1'b0;
      mode_q    <= 1'b0;
      inhib_q   <= 1'b0;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
      apu_clk_q <= 1'b0;
      e_q       <= 1'b0;
      l_q       <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      phase_q   <= phase_d;
      mode_q    <= mode_d;
      inhib_q   <= inhib_d;
      pend_q    <= pend_d;
      wrap_q    <= wrap_d;
      apu_clk_q <= apu_clk_d;
      e_q       <= e_d;
      l_q       <= l_d;
      irq_q     <= irq_d;
    end
  end

  assign apu_clk   = apu_clk_q;
  assign e_pulse   = e_q;
  assign l_pulse   = l_q;
  assign frame_irq = irq_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer (NTSC build).
// Strobe index 1 after reset release sees cnt 0.
`timescale 1ns/1ps
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_cyc = 1'b0;
  logic       wren_4017 = 1'b0;
  logic [7:0] from_cpu = 8'h00;
  logic       rd_4015 = 1'b0;
  logic       apu_clk;
  logic       e_pulse;
  logic       l_pulse;
  logic       frame_irq;

  apu_frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cyc   (cpu_cyc),
    .wren_4017 (wren_4017),
    .from_cpu  (from_cpu),
    .rd_4015   (rd_4015),
    .apu_clk   (apu_clk),
    .e_pulse   (e_pulse),
    .l_pulse   (l_pulse),
    .frame_irq (frame_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit e;
    bit l;
  } ev_t;

  ev_t expq[$];
  int  errs    = 0;
  int  checks  = 0;
  int  issued  = 0;
  int  apu_cnt = 0;
  int  r;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic push(int idx, bit e, bit l);
    ev_t v;
    v.idx = idx;
    v.e   = e;
    v.l   = l;
    expq.push_back(v);
  endtask

  task automatic drained(string nm);
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL %s: %0d pulses missing, next idx %0d",
               nm, expq.size(), expq[0].idx);
      expq.delete();
    end
  endtask

  // One cpu_cyc; returns once its outputs are visible.
  task automatic strobe(bit wr, logic [7:0] d, bit rd);
    @(negedge clk);
    cpu_cyc   = 1'b1;
    wren_4017 = wr;
    from_cpu  = d;
    rd_4015   = rd;
    issued++;
    @(posedge clk);
    #2;
    cpu_cyc   = 1'b0;
    wren_4017 = 1'b0;
    from_cpu  = 8'h00;
    rd_4015   = 1'b0;
  endtask

  task automatic idle(bit rd);
    @(negedge clk);
    cpu_cyc = 1'b0;
    rd_4015 = rd;
    @(posedge clk);
    #2;
    rd_4015 = 1'b0;
  endtask

  task automatic run_to(int n);
    while (issued < n) strobe(1'b0, 8'h00, 1'b0);
  endtask

  task automatic align(int p);
    if ((issued % 2) != p) strobe(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: pop an expectation for every pulse seen.
  initial begin
    forever begin
      ev_t v;
      @(posedge clk);
      #1;
      if (apu_clk) apu_cnt++;
      if (e_pulse || l_pulse) begin
        checks++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL pulse_unexp: idx %0d e=%0b l=%0b want none",
                   issued, e_pulse, l_pulse);
        end else begin
          v = expq.pop_front();
          if (v.idx != issued || v.e != e_pulse ||
              v.l != l_pulse) begin
            errs++;
            $display("FAIL pulse: got idx %0d e=%0b l=%0b want idx %0d e=%0b l=%0b",
                     issued, e_pulse, l_pulse, v.idx, v.e, v.l);
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit hit at strobe %0d", issued);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs",
        int'({apu_clk, e_pulse, l_pulse, frame_irq}), 0);
    @(negedge clk);
    rst = 1'b0;
    issued = 0;
    apu_cnt = 0;
    repeat (4) idle(1'b0);
    chk("idle_apu", apu_cnt, 0);

    // Full 4-step frame from reset.
    push(7458, 1'b1, 1'b0);
    push(14914, 1'b1, 1'b1);
    push(22372, 1'b1, 1'b0);
    push(29830, 1'b1, 1'b1);
    run_to(29828);
    chk("irq_pre", int'(frame_irq), 0);
    strobe(1'b0, 8'h00, 1'b0);
    chk("irq_set", int'(frame_irq), 1);
    idle(1'b1);
    chk("rd_clear", int'(frame_irq), 0);
    strobe(1'b0, 8'h00, 1'b1);
    chk("set_wins", int'(frame_irq), 1);
    chk("apu_cnt", apu_cnt, 14915);
    strobe(1'b0, 8'h00, 1'b0);
    chk("wrap_set", int'(frame_irq), 1);
    drained("frame4");

    // Inhibit write at phase 1: delay 4, IRQ stays low.
    strobe(1'b1, 8'h40, 1'b0);
    chk("inh_clr", int'(frame_irq), 0);
    r = issued + 4;
    push(r + 7458, 1'b1, 1'b0);
    push(r + 14914, 1'b1, 1'b1);
    push(r + 22372, 1'b1, 1'b0);
    push(r + 29830, 1'b1, 1'b1);
    run_to(r + 29829);
    chk("inh_28", int'(frame_irq), 0);
    strobe(1'b0, 8'h00, 1'b0);
    chk("inh_29", int'(frame_irq), 0);
    strobe(1'b0, 8'h00, 1'b0);
    chk("inh_wrap", int'(frame_irq), 0);
    drained("frame_inh");

    // 5-step write at phase 1: e+l on 4th cpu_cyc.
    align(1);
    strobe(1'b1, 8'h80, 1'b0);
    r = issued + 4;
    push(r, 1'b1, 1'b1);
    run_to(r + 1);
    drained("w80_ph1");

    // Double write at phase 0: only the second lands.
    align(0);
    strobe(1'b1, 8'h00, 1'b0);
    strobe(1'b0, 8'h00, 1'b0);
    strobe(1'b1, 8'h80, 1'b0);
    r = issued + 3;
    push(r, 1'b1, 1'b1);
    push(r + 7458, 1'b1, 1'b0);
    push(r + 14914, 1'b1, 1'b1);
    run_to(r + 20000);
    drained("w80_ph0");
    chk("irq_5step", int'(frame_irq), 0);

    // rst with a reset pending, mid-frame.
    strobe(1'b1, 8'h00, 1'b0);
    strobe(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_mid",
        int'({apu_clk, e_pulse, l_pulse, frame_irq}), 0);
    @(negedge clk);
    rst = 1'b0;
    issued = 0;
    push(7458, 1'b1, 1'b0);
    run_to(7459);
    drained("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
